// File: rtl/tour_cmd_seq_if.sv
// Command-bus bundle between the tour sequencer and its environment
// (solution memory, UART_wrapper, cmd_proc).
interface tour_cmd_seq_if #(
    parameter int unsigned IDX_W = 5
);
    logic             start_tour;
    logic [7:0]       move;
    logic [IDX_W-1:0] mv_indx;
    logic [15:0]      cmd_UART;
    logic             cmd_rdy_UART;
    logic [15:0]      cmd;
    logic             cmd_rdy;
    logic             clr_cmd_rdy;
    logic             send_resp;
    logic [7:0]       resp;
    logic             tour_busy;
    logic             move_err;

    modport master (
        output start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        input  mv_indx, cmd, cmd_rdy, resp, tour_busy, move_err
    );

    modport slave (
        input  start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        output mv_indx, cmd, cmd_rdy, resp, tour_busy, move_err
    );
endinterface

// File: rtl/tour_cmd_seq.sv
// Knight's-tour replay sequencer: each one-hot move becomes two L-leg commands muxed with UART.
// Optional macro TOUR_ABORT_EN enables a UART abort (opcode 4'hF) while the tour is busy.
module tour_cmd_seq #(
    parameter int unsigned NUM_MOVES  = 24,
    parameter int unsigned IDX_W      = 5,
    parameter bit          HORZ_FIRST = 1'b0
) (
    input logic           clk,
    input logic           rst_n,
    tour_cmd_seq_if.slave bus_io
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_MOVES - 1);
    localparam logic [7:0] HdN = 8'h00;
    localparam logic [7:0] HdW = 8'h3F;
    localparam logic [7:0] HdS = 8'h7F;
    localparam logic [7:0] HdE = 8'hBF;

    typedef enum logic [2:0] {StIdle, StLoad, StLeg1, StHold1, StLeg2, StHold2} state_e;

    state_e           state_q;
    logic [IDX_W-1:0] mv_indx_q;
    logic             move_err_q;
    logic             done_q;
    logic [15:0]      leg1_cmd_q, leg2_cmd_q;
    logic             move_ok, busy, abort_req, abort_q;
    logic [11:0]      vert_leg, horz_leg, first_leg, second_leg;

    // {heading, squares} for each leg of the one-hot move
    always_comb begin
        vert_leg = 12'h000;
        horz_leg = 12'h000;
        case (bus_io.move)
            8'h01: begin vert_leg = {HdN, 4'd2}; horz_leg = {HdE, 4'd1}; end
            8'h02: begin vert_leg = {HdN, 4'd2}; horz_leg = {HdW, 4'd1}; end
            8'h04: begin vert_leg = {HdN, 4'd1}; horz_leg = {HdW, 4'd2}; end
            8'h08: begin vert_leg = {HdS, 4'd1}; horz_leg = {HdW, 4'd2}; end
            8'h10: begin vert_leg = {HdS, 4'd2}; horz_leg = {HdW, 4'd1}; end
            8'h20: begin vert_leg = {HdS, 4'd2}; horz_leg = {HdE, 4'd1}; end
            8'h40: begin vert_leg = {HdS, 4'd1}; horz_leg = {HdE, 4'd2}; end
            8'h80: begin vert_leg = {HdN, 4'd1}; horz_leg = {HdE, 4'd2}; end
            default: begin vert_leg = 12'h000; horz_leg = 12'h000; end
        endcase
        first_leg  = HORZ_FIRST ? horz_leg : vert_leg;
        second_leg = HORZ_FIRST ? vert_leg : horz_leg;
        move_ok    = (bus_io.move != 8'h00) && ((bus_io.move & (bus_io.move - 8'd1)) == 8'h00);
    end

    assign busy = (state_q != StIdle);

`ifdef TOUR_ABORT_EN
    assign abort_req = busy && bus_io.cmd_rdy_UART && (bus_io.cmd_UART[15:12] == 4'hF);

    // Also serves as the pending-abort flag while parked in a HOLD state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abort_q <= 1'b0;
        end else if (state_q == StIdle && bus_io.start_tour) begin
            abort_q <= 1'b0;
        end else if (abort_req) begin
            abort_q <= 1'b1;
        end
    end
`else
    assign abort_req = 1'b0;
    assign abort_q   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            mv_indx_q  <= '0;
            move_err_q <= 1'b0;
            done_q     <= 1'b0;
            leg1_cmd_q <= 16'h0000;
            leg2_cmd_q <= 16'h0000;
        end else begin
            case (state_q)
                StIdle: if (bus_io.start_tour) begin
                    mv_indx_q  <= '0;
                    move_err_q <= 1'b0;
                    done_q     <= 1'b0;
                    state_q    <= StLoad;
                end
                StLoad: begin
                    if (abort_req) begin
                        state_q <= StIdle;
                    end else if (!move_ok) begin
                        move_err_q <= 1'b1;
                        state_q    <= StIdle;
                    end else begin
                        leg1_cmd_q <= {4'h4, first_leg};
                        leg2_cmd_q <= {4'h5, second_leg};
                        state_q    <= StLeg1;
                    end
                end
                StLeg1: begin
                    if (abort_req)               state_q <= StIdle;
                    else if (bus_io.clr_cmd_rdy) state_q <= StHold1;
                end
                StHold1: if (bus_io.send_resp) begin
                    state_q <= (abort_q || abort_req) ? StIdle : StLeg2;
                end
                StLeg2: begin
                    if (abort_req)               state_q <= StIdle;
                    else if (bus_io.clr_cmd_rdy) state_q <= StHold2;
                end
                StHold2: if (bus_io.send_resp) begin
                    if (abort_q || abort_req) begin
                        state_q <= StIdle;
                    end else if (mv_indx_q == LastIdx) begin
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        mv_indx_q <= mv_indx_q + IDX_W'(1);
                        state_q   <= StLoad;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Command mux: UART owns the bus only while idle
    always_comb begin
        bus_io.cmd     = leg2_cmd_q;
        bus_io.cmd_rdy = 1'b0;
        case (state_q)
            StIdle: begin
                bus_io.cmd     = bus_io.cmd_UART;
                bus_io.cmd_rdy = bus_io.cmd_rdy_UART;
            end
            StLeg1:  begin bus_io.cmd = leg1_cmd_q; bus_io.cmd_rdy = 1'b1; end
            StHold1: begin bus_io.cmd = leg1_cmd_q; bus_io.cmd_rdy = 1'b0; end
            StLeg2:  begin bus_io.cmd = leg2_cmd_q; bus_io.cmd_rdy = 1'b1; end
            default: begin bus_io.cmd = leg2_cmd_q; bus_io.cmd_rdy = 1'b0; end
        endcase
    end

    always_comb begin
        if (move_err_q) begin
            bus_io.resp = 8'hE7;
        end else if (abort_q) begin
            bus_io.resp = 8'hAB;
        end else if (mv_indx_q == LastIdx &&
                     (state_q == StHold2 || (state_q == StIdle && done_q))) begin
            bus_io.resp = 8'hA5;
        end else begin
            bus_io.resp = 8'h5A;
        end
    end

    assign bus_io.mv_indx   = mv_indx_q;
    assign bus_io.tour_busy = busy;
    assign bus_io.move_err  = move_err_q;

endmodule
